// File: rtl/func_unit_r.sv
// Functional unit behind a reservation station: waits for operands, executes with an
// op-dependent latency, then requests the CDB and broadcasts its result for one cycle.
module func_unit_r #(
  parameter logic [2:0] STATION_ID = 3'b001
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Busy,
  input  logic        Clear_counter,
  input  logic [2:0]  Ufop,
  input  logic [15:0] Vj,
  input  logic [15:0] Vk,
  input  logic [2:0]  Qj,
  input  logic [2:0]  Qk,
  input  logic        Cdb_grant,
  output logic        Done,
  output logic        Finished,
  output logic        Cdb_req,
  output logic        Cdb_valid,
  output logic [2:0]  Cdb_tag,
  output logic [15:0] Cdb_value,
  output logic [2:0]  Counter
);

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {S_IDLE, S_WAIT_OPS, S_EXEC, S_DONE, S_BCAST} state_t;

  state_t state, next_state;

  logic              start, ready, abort, enter_exec;
  logic [2:0]        ufop_p0;
  logic [DATA_W-1:0] vj_p0, vk_p0;

  logic              done_d, finished_d, req_d, valid_d;
  logic [2:0]        tag_d, counter_d;
  logic [DATA_W-1:0] value_d;

  function automatic logic [2:0] op_latency(input logic [2:0] op);
    case (op)
      3'b000, 3'b001, 3'b100: op_latency = 3'd2;
      3'b111:                 op_latency = 3'd4;
      default:                op_latency = 3'd1;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] op_result(input logic [2:0] op,
                                                  input logic [DATA_W-1:0] a,
                                                  input logic [DATA_W-1:0] b);
    logic signed [DATA_W-1:0] sa, sb;
    sa = a;
    sb = b;
    case (op)
      3'b000:  op_result = a + b;
      3'b001:  op_result = a - b;
      3'b010:  op_result = a & b;
      3'b011:  op_result = a | b;
      3'b100:  op_result = (sa < sb) ? DATA_W'(1) : '0;
      3'b101:  op_result = a << b[3:0];
      3'b110:  op_result = a >> b[3:0];
      default: op_result = a * b;
    endcase
  endfunction

  assign start      = Busy && !Clear_counter;
  assign abort      = !Busy || Clear_counter;
  assign ready      = (Qj == 3'b000) && (Qk == 3'b000);
  assign enter_exec = (next_state == S_EXEC) && (state != S_EXEC);

  always_ff @(posedge Clock) begin
    if (Reset) state <= S_IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:     if (start) next_state = ready ? S_EXEC : S_WAIT_OPS;
      S_WAIT_OPS: if (abort) next_state = S_IDLE;
                  else if (ready) next_state = S_EXEC;
      S_EXEC:     if (abort) next_state = S_IDLE;
                  else if (Counter == op_latency(ufop_p0)) next_state = S_DONE;
      S_DONE:     if (Cdb_grant) next_state = S_BCAST;
      S_BCAST:    next_state = S_IDLE;
      default:    next_state = S_IDLE;
    endcase
  end

  // Output values are decoded from the next state so every output is a flop.
  always_comb begin
    done_d     = 1'b0;
    finished_d = 1'b0;
    req_d      = 1'b0;
    valid_d    = 1'b0;
    tag_d      = 3'b000;
    value_d    = '0;
    counter_d  = 3'd0;
    case (next_state)
      S_EXEC:  counter_d = (state == S_EXEC) ? Counter + 3'd1 : 3'd1;
      S_DONE: begin
        done_d    = 1'b1;
        req_d     = 1'b1;
        counter_d = Counter;
      end
      S_BCAST: begin
        finished_d = 1'b1;
        valid_d    = 1'b1;
        tag_d      = STATION_ID;
        value_d    = op_result(ufop_p0, vj_p0, vk_p0);
        counter_d  = Counter;
      end
      default: ;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Done      <= 1'b0;
      Finished  <= 1'b0;
      Cdb_req   <= 1'b0;
      Cdb_valid <= 1'b0;
      Cdb_tag   <= 3'b000;
      Cdb_value <= '0;
      Counter   <= 3'd0;
      ufop_p0   <= 3'b000;
      vj_p0     <= '0;
      vk_p0     <= '0;
    end else begin
      Done      <= done_d;
      Finished  <= finished_d;
      Cdb_req   <= req_d;
      Cdb_valid <= valid_d;
      Cdb_tag   <= tag_d;
      Cdb_value <= value_d;
      Counter   <= counter_d;
      if (enter_exec) begin
        ufop_p0 <= Ufop;
        vj_p0   <= Vj;
        vk_p0   <= Vk;
      end
    end
  end

endmodule

// File: tb/tb_func_unit_r.sv
// Scoreboard bench for func_unit_r: stimulus pushes expected CDB results, a monitor
// pops and compares them whenever the unit broadcasts.
module tb_func_unit_r;

  logic        Clock = 1'b0;
  logic        Reset, Busy, Clear_counter, Cdb_grant;
  logic [2:0]  Ufop, Qj, Qk;
  logic [15:0] Vj, Vk;
  logic        Done, Finished, Cdb_req, Cdb_valid;
  logic [2:0]  Cdb_tag, Counter;
  logic [15:0] Cdb_value;

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  logic        prev_valid = 1'b0;

  always #5 Clock = ~Clock;

  func_unit_r #(.STATION_ID(3'b001)) dut (
    .Clock(Clock), .Reset(Reset), .Busy(Busy), .Clear_counter(Clear_counter),
    .Ufop(Ufop), .Vj(Vj), .Vk(Vk), .Qj(Qj), .Qk(Qk), .Cdb_grant(Cdb_grant),
    .Done(Done), .Finished(Finished), .Cdb_req(Cdb_req), .Cdb_valid(Cdb_valid),
    .Cdb_tag(Cdb_tag), .Cdb_value(Cdb_value), .Counter(Counter)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ref_result(input logic [2:0] op, input logic [15:0] a,
                                             input logic [15:0] b);
    longint ia = longint'(a);
    longint ib = longint'(b);
    longint sa = (ia >= 32768) ? ia - 65536 : ia;
    longint sb = (ib >= 32768) ? ib - 65536 : ib;
    longint sh = 64'd1 << (ib % 16);
    case (op)
      3'd0:    return 16'((ia + ib) % 65536);
      3'd1:    return 16'((ia - ib + 65536) % 65536);
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return (sa < sb) ? 16'd1 : 16'd0;
      3'd5:    return 16'((ia * sh) % 65536);
      3'd6:    return 16'(ia / sh);
      default: return 16'((ia * ib) % 65536);
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] op);
    case (op)
      3'd0, 3'd1, 3'd4: return 2;
      3'd7:             return 4;
      default:          return 1;
    endcase
  endfunction

  // Monitor: every broadcast must match the oldest outstanding expectation.
  always @(negedge Clock) begin
    logic [15:0] e;
    if (Reset !== 1'b1) begin
      if (Cdb_valid === 1'b1) begin
        if (exp_q.size() == 0) check("unexpected_bcast", 32'(Cdb_valid), 0);
        else begin
          e = exp_q.pop_front();
          check("cdb_value", 32'(Cdb_value), 32'(e));
          check("cdb_tag", 32'(Cdb_tag), 1);
          check("bcast_flags", {Finished, Done, Cdb_req}, 3'b100);
          check("bcast_single", 32'(prev_valid), 0);
        end
      end else begin
        check("idle_bus", {Finished, Cdb_tag, Cdb_value}, 0);
      end
    end
    prev_valid <= Cdb_valid;
  end

  task automatic recover();
    Reset = 1'b1; Busy = 1'b0; Clear_counter = 1'b0; Cdb_grant = 1'b0;
    @(negedge Clock);
    Reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int qwait, input int gdelay, input bit keep_busy);
    int cyc;
    int lat;
    lat = ref_lat(op);
    Busy = 1'b1; Clear_counter = 1'b0; Cdb_grant = 1'b0;
    Ufop = op; Vj = a; Vk = b;
    Qj = (qwait > 0 && op[0]) ? 3'b010 : 3'b000;
    Qk = (qwait > 0 && !op[0]) ? 3'b011 : 3'b000;
    for (int w = 0; w < qwait; w++) begin
      @(negedge Clock);
      check("wait_counter", 32'(Counter), 0);
      check("wait_done", 32'(Done), 0);
    end
    Qj = 3'b000; Qk = 3'b000;
    exp_q.push_back(ref_result(op, a, b));
    cyc = 0;
    do begin
      @(negedge Clock);
      cyc++;
      if (cyc == 1) begin
        Vj = 16'($urandom); Vk = 16'($urandom); Ufop = 3'($urandom);
      end
    end while (Done !== 1'b1 && cyc < 20);
    check("latency", 32'(cyc), 32'(lat + 1));
    if (Done !== 1'b1) begin
      recover();
      return;
    end
    check("done_counter", 32'(Counter), 32'(lat));
    check("done_req", 32'(Cdb_req), 1);
    Busy = 1'($urandom_range(0, 1)); Clear_counter = 1'($urandom_range(0, 1));
    repeat (gdelay) @(negedge Clock);
    if (gdelay > 0) check("done_hold", {Done, Cdb_req, Counter}, {2'b11, 3'(lat)});
    Cdb_grant = 1'b1;
    @(negedge Clock);
    Cdb_grant = 1'b0;
    Busy = keep_busy; Clear_counter = keep_busy;
    @(negedge Clock);
    check("idle_after", {Done, Finished, Counter}, 0);
    if (keep_busy) begin
      repeat (3) begin
        @(negedge Clock);
        check("no_restart", {Done, Counter}, 0);
      end
    end
    Busy = 1'b0; Clear_counter = 1'b0;
  endtask

  initial begin
    int cyc;
    Reset = 1'b1; Busy = 1'b0; Clear_counter = 1'b0; Cdb_grant = 1'b0;
    Ufop = 3'd0; Vj = 16'd0; Vk = 16'd0; Qj = 3'd0; Qk = 3'd0;
    repeat (3) @(negedge Clock);
    check("reset_outputs", {Done, Finished, Cdb_req, Cdb_valid, Cdb_tag, Cdb_value, Counter}, 0);
    Reset = 1'b0;
    @(negedge Clock);

    run_op(3'd0, 16'h7FFF, 16'h0001, 0, 0, 1'b0);
    run_op(3'd1, 16'd5, 16'd7, 3, 0, 1'b0);
    run_op(3'd7, 16'h0100, 16'h0101, 0, 5, 1'b0);
    run_op(3'd4, 16'hFFFF, 16'h0001, 0, 1, 1'b0);
    run_op(3'd6, 16'h8000, 16'h0013, 0, 0, 1'b1);
    run_op(3'd5, 16'h00F1, 16'h0004, 2, 2, 1'b0);

    // Abort in the first MUL execute cycle.
    Busy = 1'b1; Ufop = 3'd7; Vj = 16'h1234; Vk = 16'h0002; Qj = 3'd0; Qk = 3'd0;
    @(negedge Clock);
    check("abort_exec_cnt", 32'(Counter), 1);
    Clear_counter = 1'b1;
    @(negedge Clock);
    check("abort_exec", {Done, Counter}, 0);
    Busy = 1'b0; Clear_counter = 1'b0;
    repeat (6) begin
      @(negedge Clock);
      check("abort_quiet", {Done, Cdb_req, Counter}, 0);
    end

    // Abort while waiting on operands.
    Busy = 1'b1; Qj = 3'b011;
    @(negedge Clock);
    Busy = 1'b0;
    @(negedge Clock);
    Qj = 3'b000;
    repeat (3) begin
      @(negedge Clock);
      check("abort_wait", {Done, Counter}, 0);
    end

    // Reset while holding in DONE with the grant asserted.
    Busy = 1'b1; Ufop = 3'd0; Vj = 16'd3; Vk = 16'd4;
    cyc = 0;
    do begin
      @(negedge Clock);
      cyc++;
    end while (Done !== 1'b1 && cyc < 20);
    check("rst_done_reached", 32'(Done), 1);
    Cdb_grant = 1'b1; Reset = 1'b1; Busy = 1'b0;
    @(negedge Clock);
    check("rst_in_done", {Done, Finished, Cdb_req, Cdb_valid, Cdb_tag, Cdb_value, Counter}, 0);
    Reset = 1'b0; Cdb_grant = 1'b0;
    repeat (4) begin
      @(negedge Clock);
      check("rst_no_finish", {Finished, Done}, 0);
    end

    for (int i = 0; i < 40; i++) begin
      logic [15:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? 16'h8000 : 16'($urandom);
      b = ($urandom_range(0, 3) == 0) ? 16'hFFFF : 16'($urandom);
      run_op(3'($urandom_range(0, 7)), a, b, $urandom_range(0, 3), $urandom_range(0, 4),
             1'($urandom_range(0, 1)));
    end

    repeat (2) @(negedge Clock);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/func_unit_r.md
FUNC_UNIT_R -- requirements
Module: func_unit_r

Interface
REQ-001 Parameter: STATION_ID, 3'b001, tag broadcast on the CDB; must be nonzero, since 3'b000 means "no producer".
REQ-002 Reset: Reset, synchronous, active-high.
REQ-003 Clock  in  1  rising-edge clock.
REQ-004 Reset  in  1  synchronous active-high reset.
REQ-005 Busy  in  1  reservation station holds a valid instruction.
REQ-006 Clear_counter  in  1  abort/hold request from the reservation station.
REQ-007 Ufop  in  3  operation code.
REQ-008 Vj, Vk  in  16 each  operand values.
REQ-009 Qj, Qk  in  3 each  producer tags; 3'b000 = operand valid.
REQ-010 Cdb_grant  in  1  CDB arbiter grant.
REQ-011 Done  out  1  result computed, awaiting broadcast.
REQ-012 Finished  out  1  one-cycle pulse, result broadcast.
REQ-013 Cdb_req  out  1  bus request.
REQ-014 Cdb_valid  out  1  CDB data valid.
REQ-015 Cdb_tag  out  3  broadcasting station tag.
REQ-016 Cdb_value  out  16  broadcast result.
REQ-017 Counter  out  3  execution cycle count.

Function
REQ-018 The FSM SHALL have states IDLE, WAIT_OPS, EXEC, DONE and BCAST, with all outputs registered.
REQ-019 The start condition SHALL be Busy=1 and Clear_counter=0; ready SHALL mean Qj=000 and Qk=000.
REQ-020 IDLE SHALL go to EXEC on start&ready, to WAIT_OPS on start&!ready, and otherwise stay in IDLE.
REQ-021 WAIT_OPS SHALL go to EXEC when ready.
REQ-022 WAIT_OPS and EXEC SHALL abort to IDLE, with Counter=0 and no Done, when Busy=0 or Clear_counter=1.
REQ-023 On entry to EXEC, the block SHALL latch Vj, Vk and Ufop and set Counter=1.
REQ-024 In EXEC, Counter SHALL increment each cycle, and the block SHALL go to DONE when Counter equals the latency.
REQ-025 The latency SHALL be:
- ADD/SUB: 2 cycles.
- AND, OR, SLL, SRL: 1 cycle.
- SLT: 2 cycles.
- MUL: 4 cycles.
REQ-026 Ufop encoding: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT, 101 SLL, 110 SRL, 111 MUL.
REQ-027 Arithmetic rules:
- ADD/SUB: modulo 2^16, Vj-Vk, no flags.
- SLT: signed, result 16'd1 or 16'd0.
- SLL/SRL: logical, shift amount Vk[3:0].
- MUL: low 16 bits of the unsigned product.
REQ-028 In DONE, Done=1 and Cdb_req=1; the block SHALL stay in DONE until Cdb_grant=1, then go to BCAST.
REQ-029 In BCAST, for exactly one cycle, outputs SHALL be: Finished=1, Cdb_valid=1, Cdb_tag=STATION_ID, Cdb_value=result; Done=0, Cdb_req=0.
REQ-030 BCAST SHALL go to IDLE unconditionally.
REQ-031 Outside BCAST, Cdb_valid=0, Cdb_tag=000 and Cdb_value=0.
REQ-032 Busy and Clear_counter SHALL be ignored in DONE and BCAST; a started operation always completes.
REQ-033 In IDLE after BCAST, no restart SHALL occur while Clear_counter=1, even if Busy is still 1.
REQ-034 Operand or Ufop changes during EXEC, DONE or BCAST SHALL NOT affect the result.
REQ-035 Counter SHALL be 0 in IDLE and WAIT_OPS and SHALL hold its final value in DONE.

Reset
REQ-036 When Reset=1 at a clock edge, the state SHALL go to IDLE from any state, including mid-EXEC or DONE.
REQ-037 Reset values SHALL be: Done=0, Finished=0, Cdb_req=0, Cdb_valid=0, Cdb_tag=000, Cdb_value=0, Counter=0, latched operands=0.
REQ-038 A grant coinciding with Reset SHALL be ignored, and no Finished pulse SHALL follow.

Verification
REQ-039 ADD, Vj=16'h7FFF, Vk=16'h0001, Q=0, grant tied 1 -> EXEC 2 cycles, Done 1 cycle, then BCAST with Cdb_value=16'h8000, Cdb_tag=001, Finished a single pulse.
REQ-040 Start with Qj=010 for 3 cycles, then Qj=000, SUB 5-7 -> WAIT_OPS held 3 cycles, then Cdb_value=16'hFFFE.
REQ-041 MUL 16'h0100*16'h0101, grant withheld 5 cycles -> Counter reaches 4, Done and Cdb_req held 5+ cycles, Cdb_value=16'h0100 in the grant-following cycle.
REQ-042 SLT Vj=16'hFFFF, Vk=16'h0001 -> 16'd1; SRL Vj=16'h8000, Vk=16'h0013 -> 16'h1000.
REQ-043 Clear_counter=1 in EXEC cycle 1 of MUL -> IDLE next cycle, Counter=0, no Done/Finished.
REQ-044 Reset asserted in DONE with grant=1 -> next cycle all outputs at reset values, no Finished.
